// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Round-robin arbiter and sequencer placed in front of a single-port data
// memory (synchronous write, combinational read). Port 0 is the core
// load/store port and port 1 the loader/debug port. Partial byte-enable
// writes are turned into a two-cycle read-modify-write: the old word is
// captured in IDLE and the merged word is written back from MERGE.
//
// Ports (x = 0, 1):
//   clk, rst_n        clock, asynchronous active-low reset
//   px_valid/ready    request handshake (accepted when both high)
//   px_we, px_be      write flag and byte enables (be ignored on reads)
//   px_addr, wdata    word address and write data
//   px_rsp_valid      one-cycle response pulse, no backpressure
//   px_rsp_rdata      memory word as it was before the access
//   mem_we/addr/wdata memory command
//   mem_rdata         combinational read of mem_addr
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      p0_valid,
    output logic                      p0_ready,
    input  logic                      p0_we,
    input  logic [DATA_WIDTH/8-1:0]   p0_be,
    input  logic [ADDR_WIDTH-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wdata,
    output logic                      p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]     p0_rsp_rdata,

    input  logic                      p1_valid,
    output logic                      p1_ready,
    input  logic                      p1_we,
    input  logic [DATA_WIDTH/8-1:0]   p1_be,
    input  logic [ADDR_WIDTH-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wdata,
    output logic                      p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]     p1_rsp_rdata,

    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;        // 1 = port 1 was granted last
    logic                    lat_port_q, lat_port_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic [BE_WIDTH-1:0]     lat_be_q, lat_be_d;
    logic [DATA_WIDTH-1:0]   lat_wdata_q, lat_wdata_d;
    logic [DATA_WIDTH-1:0]   lat_old_q, lat_old_d;
    logic                    p0_rsp_valid_q, p0_rsp_valid_d;
    logic                    p1_rsp_valid_q, p1_rsp_valid_d;
    logic [DATA_WIDTH-1:0]   p0_rsp_rdata_q, p0_rsp_rdata_d;
    logic [DATA_WIDTH-1:0]   p1_rsp_rdata_q, p1_rsp_rdata_d;

    logic                    any_valid;
    logic                    gnt;
    logic                    req_we;
    logic [BE_WIDTH-1:0]     req_be;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    be_full;
    logic                    be_none;

    // Byte-wise merge of new write data into the old memory word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Grant: a lone requester wins; on a tie the port not granted last wins.
    assign any_valid = p0_valid | p1_valid;
    assign gnt       = (p0_valid && p1_valid) ? ~last_q : p1_valid;

    assign req_we    = gnt ? p1_we    : p0_we;
    assign req_be    = gnt ? p1_be    : p0_be;
    assign req_addr  = gnt ? p1_addr  : p0_addr;
    assign req_wdata = gnt ? p1_wdata : p0_wdata;
    assign be_full   = &req_be;
    assign be_none   = ~|req_be;

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        lat_port_d     = lat_port_q;
        lat_addr_d     = lat_addr_q;
        lat_be_d       = lat_be_q;
        lat_wdata_d    = lat_wdata_q;
        lat_old_d      = lat_old_q;
        p0_rsp_valid_d = 1'b0;
        p1_rsp_valid_d = 1'b0;
        p0_rsp_rdata_d = p0_rsp_rdata_q;
        p1_rsp_rdata_d = p1_rsp_rdata_q;
        p0_ready       = 1'b0;
        p1_ready       = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            IDLE: begin
                // rst_n gating keeps ready and the memory command quiet
                // while reset is held, even with requests pending.
                if (rst_n && any_valid) begin
                    p0_ready = ~gnt;
                    p1_ready = gnt;
                    last_d   = gnt;
                    mem_addr = req_addr;
                    if (req_we && !be_full && !be_none) begin
                        lat_port_d  = gnt;
                        lat_addr_d  = req_addr;
                        lat_be_d    = req_be;
                        lat_wdata_d = req_wdata;
                        lat_old_d   = mem_rdata;
                        state_d     = MERGE;
                    end else begin
                        // Reads, full writes and zero-BE writes finish here;
                        // the pre-write word is what gets returned.
                        mem_we    = req_we && be_full;
                        mem_wdata = (req_we && be_full) ? req_wdata : '0;
                        if (gnt) begin
                            p1_rsp_valid_d = 1'b1;
                            p1_rsp_rdata_d = mem_rdata;
                        end else begin
                            p0_rsp_valid_d = 1'b1;
                            p0_rsp_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            MERGE: begin
                mem_we    = 1'b1;
                mem_addr  = lat_addr_q;
                mem_wdata = merge_bytes(lat_wdata_q, lat_old_q, lat_be_q);
                state_d   = IDLE;
                if (lat_port_q) begin
                    p1_rsp_valid_d = 1'b1;
                    p1_rsp_rdata_d = lat_old_q;
                end else begin
                    p0_rsp_valid_d = 1'b1;
                    p0_rsp_rdata_d = lat_old_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            lat_port_q     <= 1'b0;
            lat_addr_q     <= '0;
            lat_be_q       <= '0;
            lat_wdata_q    <= '0;
            lat_old_q      <= '0;
            p0_rsp_valid_q <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p0_rsp_rdata_q <= '0;
            p1_rsp_rdata_q <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            lat_port_q     <= lat_port_d;
            lat_addr_q     <= lat_addr_d;
            lat_be_q       <= lat_be_d;
            lat_wdata_q    <= lat_wdata_d;
            lat_old_q      <= lat_old_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p0_rsp_rdata_q <= p0_rsp_rdata_d;
            p1_rsp_rdata_q <= p1_rsp_rdata_d;
        end
    end

    assign p0_rsp_valid = p0_rsp_valid_q;
    assign p1_rsp_valid = p1_rsp_valid_q;
    assign p0_rsp_rdata = p0_rsp_rdata_q;
    assign p1_rsp_rdata = p1_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter: a behavioural single-port memory (sync write,
// combinational read) is attached to the memory port. Directed scenarios
// cover reset, sequential reads, tie arbitration, full/partial/zero-BE
// writes and reset during MERGE; a randomized run is then checked against a
// transaction-level model (reference memory, last-granted pointer and a
// small response schedule indexed by cycle).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid, p0_ready, p0_we, p0_rsp_valid;
    logic [BW-1:0] p0_be;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rsp_rdata;
    logic          p1_valid, p1_ready, p1_we, p1_rsp_valid;
    logic [BW-1:0] p1_be;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Backdoor load port into the behavioural memory.
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] mem [0:1023];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_be(p0_be),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_be(p1_be),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        p0_valid = 0; p0_we = 0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 0;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        // Preload word i = i, word0 = 0xDEADBEEF, while reset is held.
        for (int i = 0; i < 16; i++) bd_write(AW'(i), (i == 0) ? 32'hDEADBEEF : DW'(i));
        p0_valid = 1; p0_we = 1; p0_be = 4'hF; p0_addr = 10'd3; p0_wdata = '1;
        p1_valid = 1; p1_addr = 10'd2;
        tick();
        vectors++; if (p0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p0_ready: got %b want 0", p0_ready); end
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p1_ready: got %b want 0", p1_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        vectors++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b%b want 00", p0_rsp_valid, p1_rsp_valid); end
        vectors++; if (p0_rsp_rdata !== '0 || p1_rsp_rdata !== '0) begin miscompares++; $display("FAIL reset_rsp_rdata: got %h/%h want 0/0", p0_rsp_rdata, p1_rsp_rdata); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_read_seq();
        p0_valid = 1; p0_we = 0; p0_addr = 10'd0;
        #1;
        vectors++; if (p0_ready !== 1'b1 || mem_addr !== 10'd0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rd0_issue: got ready=%b addr=%h we=%b want 1/0/0", p0_ready, mem_addr, mem_we); end
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd0_rsp: got v=%b d=%h want 1/deadbeef", p0_rsp_valid, p0_rsp_rdata); end
        p0_addr = 10'd4;
        #1;
        vectors++; if (p0_ready !== 1'b1) begin miscompares++; $display("FAIL rd4_ready: got %b want 1", p0_ready); end
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h4) begin miscompares++; $display("FAIL rd4_rsp: got v=%b d=%h want 1/4", p0_rsp_valid, p0_rsp_rdata); end
        p0_valid = 0;
        tick();
        vectors++; if (p0_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h4) begin miscompares++; $display("FAIL rd_hold: got v=%b d=%h want 0/4", p0_rsp_valid, p0_rsp_rdata); end
        idle_inputs();
    endtask

    task automatic test_tie();
        int g;
        pulse_reset();
        p0_valid = 1; p0_we = 0; p0_addr = 10'd5;
        p1_valid = 1; p1_we = 0; p1_addr = 10'd4;
        g = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (p0_ready !== (g == 0) || p1_ready !== (g == 1)) begin miscompares++; $display("FAIL tie_grant%0d: got %b%b want p%0d", i, p0_ready, p1_ready, g); end
            tick();
            if (g == 0) begin
                vectors++; if (p0_rsp_valid !== 1'b1 || p1_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h5) begin miscompares++; $display("FAIL tie_rsp%0d: got v=%b%b d=%h want 10/5", i, p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata); end
            end else begin
                vectors++; if (p1_rsp_valid !== 1'b1 || p0_rsp_valid !== 1'b0 || p1_rsp_rdata !== 32'h4) begin miscompares++; $display("FAIL tie_rsp%0d: got v=%b%b d=%h want 01/4", i, p0_rsp_valid, p1_rsp_valid, p1_rsp_rdata); end
            end
            g = 1 - g;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_full_write();
        p1_valid = 1; p1_we = 1; p1_be = 4'hF; p1_addr = 10'd7; p1_wdata = 32'h12345678;
        #1;
        vectors++; if (p1_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin miscompares++; $display("FAIL fw_issue: got ready=%b we=%b wd=%h want 1/1/12345678", p1_ready, mem_we, mem_wdata); end
        tick();
        vectors++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'h7) begin miscompares++; $display("FAIL fw_rsp: got v=%b d=%h want 1/7", p1_rsp_valid, p1_rsp_rdata); end
        p1_we = 0;
        tick();
        vectors++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'h12345678) begin miscompares++; $display("FAIL fw_readback: got v=%b d=%h want 1/12345678", p1_rsp_valid, p1_rsp_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_partial();
        p0_valid = 1; p0_we = 1; p0_be = 4'b0001; p0_addr = 10'd0; p0_wdata = 32'h000000AA;
        #1;
        vectors++; if (p0_ready !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL pw_issue: got ready=%b we=%b want 1/0", p0_ready, mem_we); end
        tick();
        p0_valid = 0;
        p1_valid = 1; p1_we = 0; p1_addr = 10'd0;
        #1;
        vectors++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin miscompares++; $display("FAIL pw_block: got ready=%b%b want 00", p0_ready, p1_ready); end
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL pw_merge: got we=%b a=%h wd=%h want 1/0/deadbeaa", mem_we, mem_addr, mem_wdata); end
        vectors++; if (p0_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL pw_early_rsp: got %b want 0", p0_rsp_valid); end
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pw_rsp: got v=%b d=%h want 1/deadbeef", p0_rsp_valid, p0_rsp_rdata); end
        #1;
        vectors++; if (p1_ready !== 1'b1) begin miscompares++; $display("FAIL pw_release: got %b want 1", p1_ready); end
        tick();
        vectors++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL pw_readback: got v=%b d=%h want 1/deadbeaa", p1_rsp_valid, p1_rsp_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_merge();
        p0_valid = 1; p0_we = 1; p0_be = 4'b0001; p0_addr = 10'd4; p0_wdata = 32'h000000FF;
        tick();
        idle_inputs();
        rst_n = 0;
        #1;
        vectors++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin miscompares++; $display("FAIL rm_outputs: got rdy=%b%b we=%b a=%h wd=%h want 00/0/0/0", p0_ready, p1_ready, mem_we, mem_addr, mem_wdata); end
        vectors++; if (p0_rsp_valid !== 1'b0 || p0_rsp_rdata !== '0 || p1_rsp_rdata !== '0) begin miscompares++; $display("FAIL rm_rsp: got v=%b d=%h/%h want 0/0/0", p0_rsp_valid, p0_rsp_rdata, p1_rsp_rdata); end
        tick();
        rst_n = 1;
        p0_valid = 1; p0_we = 0; p0_addr = 10'd4;
        p1_valid = 1; p1_we = 0; p1_addr = 10'd5;
        #1;
        vectors++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin miscompares++; $display("FAIL rm_tie: got %b%b want 10", p0_ready, p1_ready); end
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h4) begin miscompares++; $display("FAIL rm_word4: got v=%b d=%h want 1/4", p0_rsp_valid, p0_rsp_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_be();
        p0_valid = 1; p0_we = 1; p0_be = 4'b0000; p0_addr = 10'd5; p0_wdata = 32'hFFFFFFFF;
        #1;
        vectors++; if (p0_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5) begin miscompares++; $display("FAIL zb_issue: got ready=%b we=%b a=%h want 1/0/5", p0_ready, mem_we, mem_addr); end
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h5) begin miscompares++; $display("FAIL zb_rsp: got v=%b d=%h want 1/5", p0_rsp_valid, p0_rsp_rdata); end
        p0_we = 0;
        tick();
        vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h5) begin miscompares++; $display("FAIL zb_unchanged: got v=%b d=%h want 1/5", p0_rsp_valid, p0_rsp_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [0:15];
        logic          have [2];
        logic          rq_we [2];
        logic [BW-1:0] rq_be [2];
        logic [AW-1:0] rq_addr [2];
        logic [DW-1:0] rq_wd [2];
        logic          sch_v [4];
        int            sch_p [4];
        logic [DW-1:0] sch_d [4];
        logic [DW-1:0] last_rd [2];
        logic          last_p1;
        logic          busy;
        logic          busy_next;
        logic          got_v;
        logic [DW-1:0] got_d;
        logic [DW-1:0] old, mask;
        int            g, lat, sel;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bd_write(AW'(i), ref_mem[i]);
        end
        pulse_reset();
        for (int i = 0; i < 4; i++) sch_v[i] = 0;
        for (int p = 0; p < 2; p++) begin have[p] = 0; last_rd[p] = '0; end
        last_p1 = 1;
        busy = 0;

        for (int c = 0; c < 400; c++) begin
            // Responses scheduled for this cycle.
            for (int p = 0; p < 2; p++) begin
                if (sch_v[c % 4] && sch_p[c % 4] == p) last_rd[p] = sch_d[c % 4];
                got_v = (p == 0) ? p0_rsp_valid : p1_rsp_valid;
                got_d = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
                vectors++; if (got_v !== (sch_v[c % 4] && sch_p[c % 4] == p)) begin miscompares++; $display("FAIL rnd_rsp_valid c%0d p%0d: got %b", c, p, got_v); end
                vectors++; if (got_d !== last_rd[p]) begin miscompares++; $display("FAIL rnd_rsp_rdata c%0d p%0d: got %h want %h", c, p, got_d, last_rd[p]); end
            end
            sch_v[c % 4] = 0;

            // New requests; pending ones are held unchanged.
            for (int p = 0; p < 2; p++) begin
                if (!have[p] && $urandom_range(0, 2) != 0) begin
                    have[p]    = 1;
                    rq_we[p]   = 1'($urandom_range(0, 1));
                    sel        = $urandom_range(0, 3);
                    rq_be[p]   = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
                    rq_addr[p] = AW'($urandom_range(0, 15));
                    rq_wd[p]   = $urandom;
                end
            end
            p0_valid = have[0]; p0_we = rq_we[0]; p0_be = rq_be[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wd[0];
            p1_valid = have[1]; p1_we = rq_we[1]; p1_be = rq_be[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wd[1];
            #1;

            g = -1;
            if (!busy) begin
                if (have[0] && have[1]) g = last_p1 ? 0 : 1;
                else if (have[0]) g = 0;
                else if (have[1]) g = 1;
            end
            vectors++; if (p0_ready !== (g == 0) || p1_ready !== (g == 1)) begin miscompares++; $display("FAIL rnd_grant c%0d: got %b%b want %0d", c, p0_ready, p1_ready, g); end

            busy_next = 0;
            if (g >= 0) begin
                old = ref_mem[rq_addr[g][3:0]];
                if (rq_we[g]) begin
                    mask = '0;
                    for (int k = 0; k < BW; k++) if (rq_be[g][k]) mask = mask | (DW'(8'hFF) << (8 * k));
                    ref_mem[rq_addr[g][3:0]] = (rq_wd[g] & mask) | (old & ~mask);
                end
                busy_next = rq_we[g] && rq_be[g] != 4'h0 && rq_be[g] != 4'hF;
                lat = busy_next ? 2 : 1;
                sch_v[(c + lat) % 4] = 1;
                sch_p[(c + lat) % 4] = g;
                sch_d[(c + lat) % 4] = old;
                last_p1 = (g == 1);
                have[g] = 0;
            end
            busy = busy_next;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        bd_we = 0; bd_addr = '0; bd_data = '0;
        idle_inputs();
        rst_n = 1;
        #1;
        rst_n = 0;
        test_reset();
        test_read_seq();
        test_tie();
        test_full_write();
        test_partial();
        test_reset_merge();
        test_zero_be();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory (sync write, combinational read). It multiplexes a core load/store port (port 0) and a loader/debug port (port 1) onto the memory port using round-robin arbitration. It also adds byte-enable writes by performing a two-cycle read-modify-write. It sits between the requesters and the data memory instance.

## Interface
- ADDR_WIDTH, 10, word address width (matches data memory)
- DATA_WIDTH, 32, word width; must be a multiple of 8
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)

Ports (x = 0, 1):
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- px_valid  in  1  request valid
- px_ready  out  1  request accepted this cycle when px_valid && px_ready
- px_we  in  1  1 = write, 0 = read
- px_be  in  BE_WIDTH  byte enables for writes; ignored for reads
- px_addr  in  ADDR_WIDTH  word address
- px_wdata  in  DATA_WIDTH  write data
- px_rsp_valid  out  1  one-cycle response pulse; no backpressure
- px_rsp_rdata  out  DATA_WIDTH  memory word before the access (read data, or old contents on write)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  combinational read of mem_addr

## Operation
- FSM states: IDLE and MERGE.
- IDLE arbitration:
  - If only one px_valid is high, that port is granted.
  - If both are high, the port not granted last is granted.
  - The last-granted pointer updates on every acceptance.
  - px_ready is high only for the granted port, and only in IDLE.
- IDLE, accepted read: mem_addr = px_addr, mem_we = 0. mem_rdata is registered to that port's response.
- IDLE, accepted write with be all-ones: mem_we = 1, mem_addr = px_addr, mem_wdata = px_wdata. The old mem_rdata is registered to the response.
- IDLE, accepted write with be all-zeros: no memory write (mem_we = 0). The old word is read and acknowledged.
- IDLE, accepted partial write (be neither all-ones nor all-zeros):
  - Drive mem_addr and latch port, addr, be, wdata and mem_rdata.
  - Go to MERGE.
- MERGE:
  - mem_we = 1 to the latched addr.
  - mem_wdata byte k = be[k] ? wdata byte k : old byte k.
  - Both px_ready are 0.
  - Return to IDLE.
  - Response: rsp_rdata = old word.
- No valid request in IDLE: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Only the granted port's rsp_valid pulses. Responses return in acceptance order. The other port's rsp_rdata holds its last value.

## Timing
- Read, full or zero-BE write: accepted in cycle N; rsp_valid high in cycle N+1 only.
- Partial write: accepted in N; memory write at the end of N+1; rsp_valid in N+2.
- Throughput:
  - One access per cycle for reads and full writes, including back-to-back alternation between ports.
  - A partial write blocks both ports for 1 extra cycle.
- A read issued the cycle after a write to the same address returns the new data, because the memory write lands at the posedge.
- Reset (asynchronous, any cycle, including mid-MERGE):
  - State goes to IDLE and a pending RMW is discarded (no write).
  - Pointer = port 1 last granted, so port 0 wins the first tie.
  - px_rsp_valid = 0, px_rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - px_ready = 0 while rst_n is low.
- Requesters must hold a request stable until accepted. A request dropped before acceptance is simply not served.

## Test plan
- Memory preloaded word0 = 0xDEADBEEF, word4 = 4. p0 reads addr 0, then addr 4 on consecutive cycles -> rsp_rdata 0xDEADBEEF then 0x4, each one cycle after acceptance.
- Both ports valid every cycle (p0 reads addr 5, p1 reads addr 4) for 4 cycles after reset -> grants p0, p1, p0, p1, with p0 first.
- p1 writes 0x12345678 to addr 7, be = 1111; then p1 reads addr 7 -> write response rdata = old value, read returns 0x12345678.
- Word0 = 0xDEADBEEF; p0 writes 0x000000AA to addr 0 with be = 0001:
  - Response in N+2 with rdata 0xDEADBEEF.
  - A subsequent read returns 0xDEADBEAA.
  - p1_ready is 0 in N+1.
- Partial write to addr 4 with rst_n pulsed low during MERGE -> addr 4 still reads 0x4, outputs are at reset values, and p0 wins the next tie.
- p0 write with be = 0000 to addr 5 -> mem_we never asserts, response rdata 0x5, word unchanged.
